mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mips_pkg.sv | 13 +
 rtl/mux_n_comb.sv | 34 +++
 rtl/mux_n_pipe.sv | 119 +++++++++++
 tb/tb_mux_n_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the mux_n_pipe block: FSM state encoding
// and the default channel width.
package mips_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 word selector. A select value with no matching channel
// (sel >= N) yields an all-zero word.
module mux_n_comb
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] a_in,
  output logic [WIDTH-1:0]   y
);

  logic [N-1:0]     hit;
  logic [WIDTH-1:0] masked [N];

  // AND-OR tree: out-of-range selects hit no channel, so zero-fill is free.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign hit[gi]    = (sel == SELW'(gi));
      assign masked[gi] = a_in[gi*WIDTH +: WIDTH] & {WIDTH{hit[gi]}};
    end
  endgenerate

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      y = y | masked[k];
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N:1 mux with a valid/ready interface, a main output register and
// one skid register. Optional sticky out-of-range flag under MUX_SEL_CHECK_EN.
module mux_n_pipe
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] a_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic               sel_err
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sel_word;
  logic             accept;
  logic             xfer;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_sel (
    .sel  (sel),
    .a_in (a_in),
    .y    (sel_word)
  );

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = sel_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_d = sel_word;
        end else if (accept) begin
          skid_d  = sel_word;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs are registered, derived from the next state.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = main_q;

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q | (accept && (int'(sel) >= N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: a 4-channel 32-bit instance checked in
// order through a queue, plus a 3-channel 8-bit instance for zero-fill.
module tb_mux_n_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   sel;
  logic [127:0] a_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  y;

  logic         in_valid3;
  logic         in_ready3;
  logic [1:0]   sel3;
  logic [23:0]  a3;
  logic         out_valid3;
  logic         out_ready3;
  logic [7:0]   y3;
`ifdef MUX_SEL_CHECK_EN
  logic         sel_err;
  logic         sel_err3;
`endif

  logic [31:0]  exp_word;
  logic [31:0]  exp_q [$];
  logic [31:0]  mon_w;
  logic [31:0]  pat_a [4];
  logic [31:0]  pat_b [4];
  logic [7:0]   stall_pat;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .N(4), .SELW(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a_in      (a_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  mux_n_pipe #(.WIDTH(8), .N(3), .SELW(2)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .a_in      (a3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .y         (y3)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err   (sel_err3)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end else begin
      $display("[TB] ok   %s: %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] s, input logic [31:0] e);
    in_valid = 1'b1;
    sel      = s;
    exp_word = e;
    step();
  endtask

  // Expected words enter the scoreboard only when the handshake will accept.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(exp_word);
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL y_unexpected: got %0h, expected no output", y);
      end else begin
        mon_w = exp_q.pop_front();
        check("y_order", {32'd0, y}, {32'd0, mon_w});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_a[0] = 32'hA0A0A0A0; pat_a[1] = 32'hA1A1A1A1;
    pat_a[2] = 32'hA2A2A2A2; pat_a[3] = 32'hA3A3A3A3;
    pat_b[0] = 32'h12345678; pat_b[1] = 32'h9ABCDEF0;
    pat_b[2] = 32'h0F0F0F0F; pat_b[3] = 32'hFFFFFFFF;
    stall_pat = 8'b1011_0010;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sel        = 2'd0;
    a_in       = {pat_a[3], pat_a[2], pat_a[1], pat_a[0]};
    exp_word   = '0;
    in_valid3  = 1'b0;
    sel3       = 2'd0;
    a3         = {8'h33, 8'h22, 8'h11};
    out_ready3 = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset, then idle
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_y", {32'd0, y}, 64'd0);
    check("rst_y3", {56'd0, y3}, 64'd0);
`ifdef MUX_SEL_CHECK_EN
    check("rst_sel_err3", {63'd0, sel_err3}, 64'd0);
`endif

    // Single accept, one-cycle latency, then empty
    out_ready = 1'b1;
    offer(2'd2, 32'hA2A2A2A2);
    in_valid = 1'b0;
    check("lat_out_valid", {63'd0, out_valid}, 64'd1);
    check("lat_y", {32'd0, y}, 64'hA2A2A2A2);
    step();
    check("lat_drain", {63'd0, out_valid}, 64'd0);

    // Fill main and skid under backpressure, then drain in order
    out_ready = 1'b0;
    offer(2'd0, 32'hA0A0A0A0);
    offer(2'd1, 32'hA1A1A1A1);
    in_valid = 1'b1;
    sel      = 2'd3;
    exp_word = 32'hA3A3A3A3;
    check("two_in_ready", {63'd0, in_ready}, 64'd0);
    check("two_y", {32'd0, y}, 64'hA0A0A0A0);
    check("two_out_valid", {63'd0, out_valid}, 64'd1);
    step();
    check("stall_y_hold", {32'd0, y}, 64'hA0A0A0A0);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("skid_y", {32'd0, y}, 64'hA1A1A1A1);
    check("skid_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("skid_drain", {63'd0, out_valid}, 64'd0);

    // Ten back-to-back words at full throughput
    a_in = {pat_b[3], pat_b[2], pat_b[1], pat_b[0]};
    for (int i = 0; i < 10; i++) begin
      offer(2'(i % 4), pat_b[i % 4]);
      check("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", {63'd0, out_valid}, 64'd0);
    check("stream_queue", 64'(exp_q.size()), 64'd0);

    // Continuous offers against an irregular out_ready pattern
    a_in = {pat_a[3], pat_a[2], pat_a[1], pat_a[0]};
    for (int i = 0; i < 8; i++) begin
      out_ready = stall_pat[i];
      offer(2'(i % 4), pat_a[i % 4]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("mixed_drain", {63'd0, out_valid}, 64'd0);
    check("mixed_queue", 64'(exp_q.size()), 64'd0);

    // Narrow instance: out-of-range select gives a zero word
    in_valid3 = 1'b1;
    sel3      = 2'd3;
    step();
    check("oor_valid3", {63'd0, out_valid3}, 64'd1);
    check("oor_y3", {56'd0, y3}, 64'd0);
`ifdef MUX_SEL_CHECK_EN
    check("oor_sel_err3", {63'd0, sel_err3}, 64'd1);
`endif
    sel3 = 2'd2;
    step();
    check("ch2_y3", {56'd0, y3}, 64'h33);
    sel3 = 2'd0;
    step();
    check("ch0_y3", {56'd0, y3}, 64'h11);
`ifdef MUX_SEL_CHECK_EN
    check("sticky_sel_err3", {63'd0, sel_err3}, 64'd1);
`endif
    in_valid3 = 1'b0;
    step();
    check("drain_valid3", {63'd0, out_valid3}, 64'd0);

    // Reset from state TWO discards both held words
    out_ready = 1'b0;
    offer(2'd3, 32'hA3A3A3A3);
    offer(2'd2, 32'hA2A2A2A2);
    in_valid = 1'b0;
    check("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_y", {32'd0, y}, 64'd0);
`ifdef MUX_SEL_CHECK_EN
    check("post_rst_sel_err3", {63'd0, sel_err3}, 64'd0);
    check("sel_err_n4", {63'd0, sel_err}, 64'd0);
`endif
    out_ready = 1'b1;
    step();
    check("no_stale", {63'd0, out_valid}, 64'd0);
    offer(2'd1, 32'hA1A1A1A1);
    in_valid = 1'b0;
    check("post_rst_accept", {32'd0, y}, 64'hA1A1A1A1);
    step();
    check("final_drain", {63'd0, out_valid}, 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
